// File: rtl/color_sensor_pkg.sv
// Shared encodings for the colour-sensor interface: filter channels, output scaling,
// FSM states and power-on half-periods used by the emulator and the sensor state machine.
package color_sensor_pkg;

  localparam logic [1:0] CH_RED   = 2'b00;
  localparam logic [1:0] CH_BLUE  = 2'b01;
  localparam logic [1:0] CH_CLEAR = 2'b10;
  localparam logic [1:0] CH_GREEN = 2'b11;

  localparam logic [1:0] SC_PDOWN = 2'b00;
  localparam logic [1:0] SC_2PCT  = 2'b01;
  localparam logic [1:0] SC_20PCT = 2'b10;
  localparam logic [1:0] SC_100PCT = 2'b11;

  localparam logic [5:0] MULT_100PCT = 6'd1;
  localparam logic [5:0] MULT_20PCT  = 6'd5;
  localparam logic [5:0] MULT_2PCT   = 6'd50;

  localparam int unsigned DEF_HALF_RED   = 32'd5000;
  localparam int unsigned DEF_HALF_GREEN = 32'd6000;
  localparam int unsigned DEF_HALF_BLUE  = 32'd7000;
  localparam int unsigned DEF_HALF_CLEAR = 32'd2000;

  typedef enum logic [1:0] {
    ST_PDOWN  = 2'b00,
    ST_SETTLE = 2'b01,
    ST_RUN    = 2'b10
  } state_t;

  // Lower scaling divides the output frequency, i.e. stretches the half-period.
  function automatic logic [5:0] scale_mult(input logic [1:0] scale);
    logic [5:0] m;
    case (scale)
      SC_100PCT: m = MULT_100PCT;
      SC_20PCT:  m = MULT_20PCT;
      SC_2PCT:   m = MULT_2PCT;
      default:   m = 6'd0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/color_sensor_emulator_pin_sync.sv
// Parameterised-width two-flop synchronizer for the asynchronous sensor control pins.
module pin_sync #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= '0;
      r_q    <= '0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/color_sensor_emulator.sv
// TCS3200-style light-to-frequency responder: emulates signal_out for the selected filter
// and scaling, with run-time programmable per-channel half-periods.
module color_sensor_emulator
  import color_sensor_pkg::*;
#(
  parameter int CNT_W         = 24,
  parameter int SETTLE_CYCLES = 10000
) (
  input  logic             CLK100MHZ,
  input  logic             reset,
  input  logic             S0,
  input  logic             S1,
  input  logic             S2,
  input  logic             S3,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_chan,
  input  logic [CNT_W-1:0] cfg_half_period,
  output logic             signal_out,
  output logic             settling,
  output logic [1:0]       chan_active
);

  localparam int PW = CNT_W + 6;
  localparam logic [PW-1:0] L_ONE        = PW'(1);
  localparam logic [PW-1:0] L_SETTLE_LD  = PW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_MIN_HALF = CNT_W'(2);

  logic [3:0]       w_sync;
  logic [1:0]       w_sync_scale;
  logic [1:0]       w_sync_sel;
  logic             w_change;
  logic             w_cfg_we;
  logic [CNT_W-1:0] w_cfg_clamped;
  logic [PW-1:0]    w_effective;

  logic [CNT_W-1:0] r_half_period [4];
  state_t           r_state;
  logic [1:0]       r_active_scale;
  logic [1:0]       r_active_sel;
  logic [PW-1:0]    r_count;
  logic             r_signal_out;
  logic             r_settling;

  pin_sync #(.W(4)) u_pin_sync (
    .i_clk (CLK100MHZ),
    .i_rst (reset),
    .i_d   ({S0, S1, S2, S3}),
    .o_q   (w_sync)
  );

  assign w_sync_scale  = w_sync[3:2];
  assign w_sync_sel    = w_sync[1:0];
  assign w_change      = (w_sync_scale != r_active_scale) || (w_sync_sel != r_active_sel);
  assign cfg_ready     = ~reset;
  assign w_cfg_we      = cfg_valid && cfg_ready;
  assign w_cfg_clamped = (cfg_half_period < L_MIN_HALF) ? L_MIN_HALF : cfg_half_period;
  // Full-width product: base x 50 fits in CNT_W+6 bits, so no saturation is needed.
  assign w_effective   = PW'(r_half_period[r_active_sel]) * PW'(scale_mult(r_active_scale));

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_half_period[CH_RED]   <= CNT_W'(DEF_HALF_RED);
      r_half_period[CH_BLUE]  <= CNT_W'(DEF_HALF_BLUE);
      r_half_period[CH_CLEAR] <= CNT_W'(DEF_HALF_CLEAR);
      r_half_period[CH_GREEN] <= CNT_W'(DEF_HALF_GREEN);
    end else if (w_cfg_we) begin
      r_half_period[cfg_chan] <= w_cfg_clamped;
    end
  end

  // Reloads read the register before this edge's write, so a half in flight never changes.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_state        <= ST_PDOWN;
      r_active_scale <= SC_PDOWN;
      r_active_sel   <= CH_RED;
      r_count        <= '0;
      r_signal_out   <= 1'b0;
      r_settling     <= 1'b0;
    end else if (w_sync_scale == SC_PDOWN) begin
      r_state        <= ST_PDOWN;
      r_active_scale <= SC_PDOWN;
      r_count        <= '0;
      r_signal_out   <= 1'b0;
      r_settling     <= 1'b0;
    end else begin
      case (r_state)
        ST_PDOWN: begin
          r_state        <= ST_SETTLE;
          r_active_scale <= w_sync_scale;
          r_active_sel   <= w_sync_sel;
          r_count        <= L_SETTLE_LD;
          r_signal_out   <= 1'b0;
          r_settling     <= 1'b1;
        end
        ST_SETTLE: begin
          if (w_change) begin
            r_active_scale <= w_sync_scale;
            r_active_sel   <= w_sync_sel;
            r_count        <= L_SETTLE_LD;
          end else if (r_count == '0) begin
            r_state      <= ST_RUN;
            r_count      <= w_effective - L_ONE;
            r_signal_out <= 1'b1;
            r_settling   <= 1'b0;
          end else begin
            r_count <= r_count - L_ONE;
          end
        end
        ST_RUN: begin
          if (w_change) begin
            r_state        <= ST_SETTLE;
            r_active_scale <= w_sync_scale;
            r_active_sel   <= w_sync_sel;
            r_count        <= L_SETTLE_LD;
            r_signal_out   <= 1'b0;
            r_settling     <= 1'b1;
          end else if (r_count == '0) begin
            r_count      <= w_effective - L_ONE;
            r_signal_out <= ~r_signal_out;
          end else begin
            r_count <= r_count - L_ONE;
          end
        end
        default: begin
          r_state      <= ST_PDOWN;
          r_count      <= '0;
          r_signal_out <= 1'b0;
          r_settling   <= 1'b0;
        end
      endcase
    end
  end

  assign signal_out  = r_signal_out;
  assign settling    = r_settling;
  assign chan_active = r_active_sel;

endmodule

// File: tb/tb_color_sensor_emulator.sv
// Directed bench: a vector table of pin settings with hand-computed half-periods, plus
// sequences for config writes, clamping, power-down and mid-run reset.
module tb_color_sensor_emulator;

  localparam int CNT_W  = 24;
  localparam int SETTLE = 100;

  logic             clk = 1'b0;
  logic             reset;
  logic             S0, S1, S2, S3;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_chan;
  logic [CNT_W-1:0] cfg_half_period;
  logic             signal_out;
  logic             settling;
  logic [1:0]       chan_active;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  color_sensor_emulator #(.CNT_W(CNT_W), .SETTLE_CYCLES(SETTLE)) dut (
    .CLK100MHZ       (clk),
    .reset           (reset),
    .S0              (S0),
    .S1              (S1),
    .S2              (S2),
    .S3              (S3),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_chan        (cfg_chan),
    .cfg_half_period (cfg_half_period),
    .signal_out      (signal_out),
    .settling        (settling),
    .chan_active     (chan_active)
  );

  typedef struct {
    logic [1:0] scale;
    logic [1:0] sel;
    int         half;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic set_pins(input logic [1:0] scale, input logic [1:0] sel);
    {S0, S1} = scale;
    {S2, S3} = sel;
  endtask

  // Counts consecutive negedge samples at which the chosen output holds lvl.
  task automatic run_len(input int which, input logic lvl, input int budget, output int n);
    n = 0;
    while ((((which == 0) ? signal_out : settling) === lvl) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_settle_start(output int n);
    n = 0;
    while ((settling !== 1'b1) && (n < 10)) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic cfg_write(input logic [1:0] chan, input int val);
    cfg_valid       = 1'b1;
    cfg_chan        = chan;
    cfg_half_period = CNT_W'(val);
    @(negedge clk);
    cfg_valid       = 1'b0;
  endtask

  // Pin change through settle into one full output period.
  task automatic settle_and_period(input string tag, input int half);
    int n;
    wait_settle_start(n);
    check({tag, "_settle_latency"}, n, 3);
    check({tag, "_low_in_settle"}, signal_out, 0);
    run_len(1, 1'b1, SETTLE + 10, n);
    check({tag, "_settle_len"}, n, SETTLE);
    check({tag, "_rise_at_run"}, signal_out, 1);
    run_len(0, 1'b1, half + 10, n);
    check({tag, "_high_len"}, n, half);
    run_len(0, 1'b0, half + 10, n);
    check({tag, "_low_len"}, n, half);
  endtask

  initial begin
    int n;
    int ones;
    vecs[0] = '{2'b11, 2'b00, 5000};
    vecs[1] = '{2'b11, 2'b11, 6000};
    vecs[2] = '{2'b11, 2'b01, 40};
    vecs[3] = '{2'b10, 2'b01, 200};
    vecs[4] = '{2'b01, 2'b01, 2000};
    vecs[5] = '{2'b11, 2'b10, 30};
    vecs[6] = '{2'b10, 2'b10, 150};

    reset = 1'b1;
    cfg_valid = 1'b0;
    cfg_chan = 2'b00;
    cfg_half_period = '0;
    set_pins(2'b00, 2'b00);
    repeat (3) @(negedge clk);
    check("rst_signal_out", signal_out, 0);
    check("rst_settling", settling, 0);
    check("rst_chan_active", chan_active, 0);
    check("rst_cfg_ready", cfg_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    check("cfg_ready_up", cfg_ready, 1);

    // Shrink blue and clear so the scaled periods stay short.
    cfg_write(2'b01, 40);
    cfg_write(2'b10, 30);
    repeat (5) @(negedge clk);
    check("pdown_idle_low", signal_out, 0);

    for (int i = 0; i < 7; i++) begin
      set_pins(vecs[i].scale, vecs[i].sel);
      settle_and_period($sformatf("vec%0d", i), vecs[i].half);
      check($sformatf("vec%0d_chan_active", i), chan_active, vecs[i].sel);
    end

    // Write red=100 mid high phase: the 5000 half in flight completes first.
    set_pins(2'b11, 2'b00);
    wait_settle_start(n);
    check("red_settle_latency", n, 3);
    run_len(1, 1'b1, SETTLE + 10, n);
    repeat (10) @(negedge clk);
    cfg_write(2'b00, 100);
    run_len(0, 1'b1, 5010, n);
    check("cfg_old_half_completes", n + 11, 5000);
    run_len(0, 1'b0, 200, n);
    check("cfg_new_low", n, 100);
    // Write 0 on the last high cycle so it lands with the reload edge.
    repeat (99) @(negedge clk);
    check("last_high_sample", signal_out, 1);
    cfg_write(2'b00, 0);
    check("toggle_on_reload", signal_out, 0);
    run_len(0, 1'b0, 200, n);
    check("same_cycle_old_value", n, 100);
    run_len(0, 1'b1, 20, n);
    check("clamp_high", n, 2);
    run_len(0, 1'b0, 20, n);
    check("clamp_low", n, 2);

    // Power-down mid-run, then recover.
    set_pins(2'b00, 2'b00);
    repeat (3) @(negedge clk);
    check("pdown_signal", signal_out, 0);
    check("pdown_settling", settling, 0);
    ones = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (signal_out !== 1'b0 || settling !== 1'b0) ones++;
    end
    check("pdown_stays_quiet", ones, 0);
    set_pins(2'b11, 2'b00);
    settle_and_period("pdown_recover", 2);

    // Reset mid-run after a config write restores defaults.
    cfg_write(2'b11, 9);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_signal_out", signal_out, 0);
    check("midrst_settling", settling, 0);
    check("midrst_chan_active", chan_active, 0);
    check("midrst_cfg_ready", cfg_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    settle_and_period("after_reset", 5000);
    check("after_reset_chan", chan_active, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
